collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Sequential initiator that sweeps an object table and tests one reference rectangle (player/bullet) against every table entry.
- Issues one synchronous table read per cycle and compares each returned entry in a one-stage pipeline.
- Reports hit flag, lowest hit index and hit count to game logic once per frame-tick start.
- Position format: 19-bit {x[9:0], y[8:0]}; width and height are 6 bits each.

Parameters:
- NUM_OBJ, 16, number of table entries scanned (2..64).
- IDX_W, $clog2(NUM_OBJ), width of table address and hit index.

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_Start  in  1  scan request, sampled in IDLE only
- i_RefPos  in  19  reference {x,y}, latched on accepted start
- i_RefWidth  in  6  reference width, latched on accepted start
- i_RefHeight  in  6  reference height, latched on accepted start
- o_RdEn  out  1  table read strobe
- o_RdAddr  out  IDX_W  table read address
- i_RdPos  in  19  entry {x,y}, valid 1 cycle after o_RdEn
- i_RdWidth  in  6  entry width, same timing as i_RdPos
- i_RdHeight  in  6  entry height, same timing as i_RdPos
- i_RdActive  in  1  entry active flag, same timing as i_RdPos; 0 means the entry is ignored
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle pulse when results are final
- o_Hit  out  1  at least one overlap found
- o_HitIdx  out  IDX_W  lowest overlapping index; 0 if none
- o_HitCount  out  IDX_W+1  number of overlapping entries

Behaviour:
- Reset: state IDLE. All outputs 0, including o_RdAddr, o_HitIdx and o_HitCount. Internal reference registers are cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: if i_Start=1, latch the reference inputs, clear accumulators, and go to READ. o_Busy rises the next cycle.
- READ: o_RdEn=1 and o_RdAddr=k, with k incrementing 0..NUM_OBJ-1 one per cycle.
  - Data for address k is compared in the following cycle.
  - After issuing k=NUM_OBJ-1, go to DRAIN.
- DRAIN: o_RdEn=0. Compare the last entry, then go to DONE.
- DONE: o_Done=1 for one cycle, then go to IDLE.
- Latency: start sampled at cycle T gives reads at T+1..T+NUM_OBJ, DRAIN at T+NUM_OBJ+1, o_Done at T+NUM_OBJ+2.
- o_Busy=1 in READ, DRAIN and DONE.
- Result outputs update only on the transition into DONE, not while accumulators change. They hold until the next DONE. They do not clear on start.
- i_Start while busy is ignored and not queued. Start in the DONE cycle is also ignored.
- Overlap test: strict, so touching edges do not count.
  - Overlap requires x overlap: refX < eX+eW and eX < refX+refW.
  - Overlap also requires y overlap: refY < eY+eH and eY < refY+refH.
  - Sums are computed at 11 bits (x) and 10 bits (y). No wrap.
  - Zero width or zero height never overlaps.
- Accumulation: a hit counts only when i_RdActive=1. The first hit sets the index; later hits only increment the count. Max count is NUM_OBJ and does not saturate.
- Async reset mid-scan: immediate return to IDLE with all outputs 0. No o_Done is emitted.

Optional Feature:
- Macro: COLLISION_SCANNER_SELF_SKIP_EN.
- Defined: adds port i_SelfIdx (in, IDX_W), latched on accepted start. The entry at that index is never counted, so a table-resident object can scan against itself.
- Undefined: the port is absent and all entries are eligible.

Decomposition:
- Shared package: X_W=10, Y_W=9, POS_W=19, SIZE_W=6, and the scanner state enum. The existing collision logic uses the same widths.
- One sub-module, rect_overlap: combinational strict-overlap test on two {pos, w, h} tuples, output 1 bit. Instantiated once on the compare stage.

Test Plan:
- Basic hit: ref (100,100,16,16); entry 3 = (110,110,8,8) active, all others at (500,400,4,4). Expect o_Done at T+18, o_Hit=1, o_HitIdx=3, o_HitCount=1.
- Touching edge: entry 2 = (116,100,8,8), ref as above. Expect o_Hit=0, o_HitIdx=0, o_HitCount=0.
- Multiple hits: entries 5 and 9 overlap, entry 7 overlaps but has i_RdActive=0. Expect o_HitIdx=5, o_HitCount=2.
- No wrap: ref (5,5,16,16); entry 0 = (1015,500,63,63). Expect no hit.
- Start while busy: pulse i_Start at T and at T+4. Expect exactly one o_Done, at T+18, and o_RdAddr sequence 0..15 once.
- Reset mid-scan: assert i_Rst_n=0 at T+6. Expect immediate o_Busy=0, outputs 0, no o_Done. A new start then completes normally.

Source files
------------

// File: rtl/collision_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_scanner_pkg
// Description : Shared widths and the scanner state encoding for the
//               collision scanner slice. Positions are packed {x, y} with a
//               10-bit x and a 9-bit y; object sizes are 6 bits per axis.
// Optional    : COLLISION_SCANNER_SELF_SKIP_EN (used by the interface/top)
// Revision    : 1.0 - initial release
// ============================================================================
package collision_scanner_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int POS_W  = X_W + Y_W;
    localparam int SIZE_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/collision_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : collision_scanner_if
// Description : Bundle between the collision scanner and its environment
//               (game logic request/result side and object-table read port).
//   master : scanner side  - drives o_* (read strobe/address, status, results)
//   slave  : environment   - drives i_* (start, reference rect, table data)
// Optional    : COLLISION_SCANNER_SELF_SKIP_EN adds i_SelfIdx
// Revision    : 1.0 - initial release
// ============================================================================
interface collision_scanner_if #(
    parameter int NUM_OBJ = 16,
    parameter int IDX_W   = $clog2(NUM_OBJ)
);
    import collision_scanner_pkg::*;

    // Request from game logic
    logic                  i_Start;
    logic [POS_W-1:0]      i_RefPos;
    logic [SIZE_W-1:0]     i_RefWidth;
    logic [SIZE_W-1:0]     i_RefHeight;
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
    logic [IDX_W-1:0]      i_SelfIdx;
`endif

    // Object table read port
    logic                  o_RdEn;
    logic [IDX_W-1:0]      o_RdAddr;
    logic [POS_W-1:0]      i_RdPos;
    logic [SIZE_W-1:0]     i_RdWidth;
    logic [SIZE_W-1:0]     i_RdHeight;
    logic                  i_RdActive;

    // Status and results
    logic                  o_Busy;
    logic                  o_Done;
    logic                  o_Hit;
    logic [IDX_W-1:0]      o_HitIdx;
    logic [IDX_W:0]        o_HitCount;

    modport master (
        input  i_Start, i_RefPos, i_RefWidth, i_RefHeight,
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
        input  i_SelfIdx,
`endif
        input  i_RdPos, i_RdWidth, i_RdHeight, i_RdActive,
        output o_RdEn, o_RdAddr,
        output o_Busy, o_Done, o_Hit, o_HitIdx, o_HitCount
    );

    modport slave (
        output i_Start, i_RefPos, i_RefWidth, i_RefHeight,
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
        output i_SelfIdx,
`endif
        output i_RdPos, i_RdWidth, i_RdHeight, i_RdActive,
        input  o_RdEn, o_RdAddr,
        input  o_Busy, o_Done, o_Hit, o_HitIdx, o_HitCount
    );

endinterface
`default_nettype wire

// File: rtl/collision_scanner_rect_overlap.sv
`default_nettype none
// ============================================================================
// Module      : rect_overlap
// Description : Combinational strict overlap test of two axis-aligned
//               rectangles given as {x, y} position plus width/height.
//               Touching edges do not overlap; a zero extent on either
//               rectangle never overlaps. Far edges are formed one bit wider
//               than the coordinate so they never wrap.
//   i_a_pos/i_a_w/i_a_h : first rectangle
//   i_b_pos/i_b_w/i_b_h : second rectangle
//   o_overlap           : 1 when the interiors intersect
// Revision    : 1.0 - initial release
// ============================================================================
module rect_overlap
    import collision_scanner_pkg::*;
(
    input  logic [POS_W-1:0]  i_a_pos,
    input  logic [SIZE_W-1:0] i_a_w,
    input  logic [SIZE_W-1:0] i_a_h,
    input  logic [POS_W-1:0]  i_b_pos,
    input  logic [SIZE_W-1:0] i_b_w,
    input  logic [SIZE_W-1:0] i_b_h,
    output logic              o_overlap
);

    logic [X_W:0] w_ax, w_bx, w_ax_end, w_bx_end;
    logic [Y_W:0] w_ay, w_by, w_ay_end, w_by_end;
    logic         w_nonzero;

    assign w_ax = {1'b0, i_a_pos[POS_W-1 -: X_W]};
    assign w_bx = {1'b0, i_b_pos[POS_W-1 -: X_W]};
    assign w_ay = {1'b0, i_a_pos[Y_W-1:0]};
    assign w_by = {1'b0, i_b_pos[Y_W-1:0]};

    assign w_ax_end = w_ax + {{(X_W+1-SIZE_W){1'b0}}, i_a_w};
    assign w_bx_end = w_bx + {{(X_W+1-SIZE_W){1'b0}}, i_b_w};
    assign w_ay_end = w_ay + {{(Y_W+1-SIZE_W){1'b0}}, i_a_h};
    assign w_by_end = w_by + {{(Y_W+1-SIZE_W){1'b0}}, i_b_h};

    // The strict inequalities alone would let a zero-width rectangle lying
    // inside the other one pass, so zero extents are rejected explicitly.
    assign w_nonzero = (|i_a_w) & (|i_a_h) & (|i_b_w) & (|i_b_h);

    assign o_overlap = w_nonzero
                     & (w_ax < w_bx_end) & (w_bx < w_ax_end)
                     & (w_ay < w_by_end) & (w_by < w_ay_end);

endmodule
`default_nettype wire

// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
// Module      : collision_scanner
// Description : Sweeps an object table with one synchronous read per cycle
//               and tests a latched reference rectangle against every entry
//               in a one-stage compare pipeline. Reports hit flag, lowest
//               hit index and hit count once per scan.
//   i_Clk    : system clock
//   i_Rst_n  : asynchronous active-low reset
//   bus      : collision_scanner_if.master (request, table port, results)
// Optional    : COLLISION_SCANNER_SELF_SKIP_EN - latch i_SelfIdx on start and
//               never count the entry at that index.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int NUM_OBJ = 16,
    parameter int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    collision_scanner_if.master bus
);

    localparam logic [IDX_W-1:0] c_LAST_ADDR = IDX_W'(NUM_OBJ - 1);

    scan_state_t        r_state, w_state_nxt;
    logic               w_accept;
    logic               w_rd_en, w_busy, w_done;

    logic [IDX_W-1:0]   r_rd_addr;
    logic [POS_W-1:0]   r_ref_pos;
    logic [SIZE_W-1:0]  r_ref_w, r_ref_h;
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
    logic [IDX_W-1:0]   r_self_idx;
`endif

    // Compare stage: tags the table data arriving this cycle
    logic               r_cmp_valid;
    logic [IDX_W-1:0]   r_cmp_idx;

    logic               r_acc_hit;
    logic [IDX_W-1:0]   r_acc_idx;
    logic [IDX_W:0]     r_acc_count;

    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [IDX_W:0]     r_hit_count;

    logic               w_overlap, w_self, w_hit_now;
    logic               w_acc_hit_nxt;
    logic [IDX_W-1:0]   w_acc_idx_nxt;
    logic [IDX_W:0]     w_acc_count_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.i_Start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_rd_en = 1'b1;
                if (r_rd_addr == c_LAST_ADDR) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Compare stage
    // ------------------------------------------------------------------
    rect_overlap u_rect_overlap (
        .i_a_pos   (r_ref_pos),
        .i_a_w     (r_ref_w),
        .i_a_h     (r_ref_h),
        .i_b_pos   (bus.i_RdPos),
        .i_b_w     (bus.i_RdWidth),
        .i_b_h     (bus.i_RdHeight),
        .o_overlap (w_overlap)
    );

`ifdef COLLISION_SCANNER_SELF_SKIP_EN
    assign w_self = (r_cmp_idx == r_self_idx);
`else
    assign w_self = 1'b0;
`endif

    assign w_hit_now = r_cmp_valid & bus.i_RdActive & w_overlap & ~w_self;

    // Index is captured by the first hit only; addresses ascend, so the
    // first hit is also the lowest one.
    assign w_acc_hit_nxt   = r_acc_hit | w_hit_now;
    assign w_acc_idx_nxt   = (w_hit_now && !r_acc_hit) ? r_cmp_idx : r_acc_idx;
    assign w_acc_count_nxt = r_acc_count + {{IDX_W{1'b0}}, w_hit_now};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_rd_addr   <= '0;
            r_ref_pos   <= '0;
            r_ref_w     <= '0;
            r_ref_h     <= '0;
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
            r_self_idx  <= '0;
`endif
            r_cmp_valid <= 1'b0;
            r_cmp_idx   <= '0;
            r_acc_hit   <= 1'b0;
            r_acc_idx   <= '0;
            r_acc_count <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_hit_count <= '0;
        end else begin
            r_cmp_valid <= w_rd_en;
            r_cmp_idx   <= r_rd_addr;

            if (w_accept) begin
                r_ref_pos   <= bus.i_RefPos;
                r_ref_w     <= bus.i_RefWidth;
                r_ref_h     <= bus.i_RefHeight;
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
                r_self_idx  <= bus.i_SelfIdx;
`endif
                r_acc_hit   <= 1'b0;
                r_acc_idx   <= '0;
                r_acc_count <= '0;
            end else if (r_cmp_valid) begin
                r_acc_hit   <= w_acc_hit_nxt;
                r_acc_idx   <= w_acc_idx_nxt;
                r_acc_count <= w_acc_count_nxt;
            end

            // Address returns to 0 after the last read so a non power-of-two
            // table does not leave it at an out-of-range value.
            if (r_state == ST_READ) begin
                r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0
                                                        : r_rd_addr + IDX_W'(1);
            end

            // DRAIN carries the last compare; publish including it, so the
            // results change exactly on entry to DONE.
            if (r_state == ST_DRAIN) begin
                r_hit       <= w_acc_hit_nxt;
                r_hit_idx   <= w_acc_idx_nxt;
                r_hit_count <= w_acc_count_nxt;
            end
        end
    end

    assign bus.o_RdEn     = w_rd_en;
    assign bus.o_RdAddr   = r_rd_addr;
    assign bus.o_Busy     = w_busy;
    assign bus.o_Done     = w_done;
    assign bus.o_Hit      = r_hit;
    assign bus.o_HitIdx   = r_hit_idx;
    assign bus.o_HitCount = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scanner
// Description : Self-checking bench for collision_scanner. A behavioural
//               model computes each scan's results from the object table with
//               integer arithmetic and tracks the expected cycle position of
//               the scan; a compare process checks every cycle. Directed scans
//               pin the model with hand-computed results; randomized scans
//               follow.
// Optional    : COLLISION_SCANNER_SELF_SKIP_EN (drives i_SelfIdx if defined)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scanner;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    collision_scanner_if #(.NUM_OBJ(N)) bus ();

    collision_scanner #(.NUM_OBJ(N)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_rden   = 0;
    int last_done = -1;
    int self_sel = N - 1;

    // Object table contents
    int tx [N];
    int ty [N];
    int tw [N];
    int th [N];
    bit tact [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ovl(input int ax, ay, aw, ah, bx, by, bw, bh);
        if (aw == 0 || ah == 0 || bw == 0 || bh == 0) return 1'b0;
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Table memory: synchronous read, data one cycle after the strobe.
    // Strobe/address are captured away from the active edge.
    // ------------------------------------------------------------------
    logic          pend_en = 1'b0;
    logic [IW-1:0] pend_addr = '0;
    always @(negedge clk) begin
        pend_en   = bus.o_RdEn;
        pend_addr = bus.o_RdAddr;
    end
    always @(posedge clk) begin
        if (pend_en) begin
            bus.i_RdPos    <= {10'(tx[pend_addr]), 9'(ty[pend_addr])};
            bus.i_RdWidth  <= 6'(tw[pend_addr]);
            bus.i_RdHeight <= 6'(th[pend_addr]);
            bus.i_RdActive <= tact[pend_addr];
        end else begin
            bus.i_RdPos    <= 19'($urandom);
            bus.i_RdWidth  <= 6'($urandom);
            bus.i_RdHeight <= 6'($urandom);
            bus.i_RdActive <= 1'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: phase = cycles since the accepted start (-1 idle).
    // Results are computed at acceptance from the static table.
    // ------------------------------------------------------------------
    int phase = -1;
    bit p_hit, m_hit;
    int p_idx, p_cnt, m_idx, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = -1;
            m_hit = 1'b0; m_idx = 0; m_cnt = 0;
        end else if (phase == -1) begin
            if (bus.i_Start === 1'b1) begin
                int rx, ry, rw, rh, self;
                rx = int'(bus.i_RefPos[18:9]);
                ry = int'(bus.i_RefPos[8:0]);
                rw = int'(bus.i_RefWidth);
                rh = int'(bus.i_RefHeight);
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
                self = int'(bus.i_SelfIdx);
`else
                self = -1;
`endif
                p_hit = 1'b0; p_idx = 0; p_cnt = 0;
                for (int i = 0; i < N; i++) begin
                    if (tact[i] && i != self &&
                        ovl(rx, ry, rw, rh, tx[i], ty[i], tw[i], th[i])) begin
                        if (!p_hit) p_idx = i;
                        p_hit = 1'b1;
                        p_cnt++;
                    end
                end
                phase = 1;
            end
        end else if (phase == N + 2) begin
            phase = -1;
        end else begin
            phase++;
            if (phase == N + 2) begin
                m_hit = p_hit; m_idx = p_idx; m_cnt = p_cnt;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(bus.o_Busy), 32'(phase >= 1));
            check("done", 32'(bus.o_Done), 32'(phase == N + 2));
            check("rd_en", 32'(bus.o_RdEn), 32'(phase >= 1 && phase <= N));
            if (phase >= 1 && phase <= N)
                check("rd_addr", 32'(bus.o_RdAddr), 32'(phase - 1));
            check("hit", 32'(bus.o_Hit), 32'(m_hit));
            check("hit_idx", 32'(bus.o_HitIdx), 32'(m_idx));
            check("hit_count", 32'(bus.o_HitCount), 32'(m_cnt));
        end else begin
            check("rst_busy", 32'(bus.o_Busy), 32'd0);
            check("rst_done", 32'(bus.o_Done), 32'd0);
            check("rst_rd_en", 32'(bus.o_RdEn), 32'd0);
            check("rst_rd_addr", 32'(bus.o_RdAddr), 32'd0);
            check("rst_hit", 32'(bus.o_Hit), 32'd0);
            check("rst_hit_idx", 32'(bus.o_HitIdx), 32'd0);
            check("rst_hit_count", 32'(bus.o_HitCount), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (bus.o_Done === 1'b1) begin
            n_done++;
            last_done = cyc;
        end
        if (bus.o_RdEn === 1'b1) n_rden++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tbl_default();
        for (int i = 0; i < N; i++) begin
            tx[i] = 500; ty[i] = 400; tw[i] = 4; th[i] = 4; tact[i] = 1'b1;
        end
    endtask

    task automatic set_ent(input int i, input int x, input int y, input int w, input int h, input bit a);
        tx[i] = x; ty[i] = y; tw[i] = w; th[i] = h; tact[i] = a;
    endtask

    task automatic drive_ref(input int rx, input int ry, input int rw, input int rh);
        bus.i_RefPos    = {10'(rx), 9'(ry)};
        bus.i_RefWidth  = 6'(rw);
        bus.i_RefHeight = 6'(rh);
`ifdef COLLISION_SCANNER_SELF_SKIP_EN
        bus.i_SelfIdx   = IW'(self_sel);
`endif
    endtask

    // Start a scan (start held 'hold' cycles), scramble the reference inputs
    // afterwards and return at the o_Done cycle with its latency.
    task automatic do_scan(input int rx, input int ry, input int rw, input int rh,
                           input int hold, output int lat);
        int t0;
        @(negedge clk);
        drive_ref(rx, ry, rw, rh);
        bus.i_Start = 1'b1;
        t0 = cyc;
        repeat (hold) @(negedge clk);
        bus.i_Start = 1'b0;
        drive_ref(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_Done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check("done_latency", 32'(lat), 32'(N + 2));
    endtask

    task automatic check_res(input string tag, input int h, input int idx, input int cnt);
        check({tag, "_hit"}, 32'(bus.o_Hit), 32'(h));
        check({tag, "_idx"}, 32'(bus.o_HitIdx), 32'(idx));
        check({tag, "_count"}, 32'(bus.o_HitCount), 32'(cnt));
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int lat, t0, d0, r0;
        bus.i_Start = 1'b0;
        drive_ref(0, 0, 0, 0);
        tbl_default();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic hit
        tbl_default();
        set_ent(3, 110, 110, 8, 8, 1'b1);
        do_scan(100, 100, 16, 16, 1, lat);
        check_res("basic", 1, 3, 1);

        // Multiple hits, one inactive overlapping entry
        tbl_default();
        set_ent(5, 110, 110, 8, 8, 1'b1);
        set_ent(7, 104, 104, 4, 4, 1'b0);
        set_ent(9, 96, 96, 8, 8, 1'b1);
        do_scan(100, 100, 16, 16, 1, lat);
        check_res("multi", 1, 5, 2);

        // Touching edge
        tbl_default();
        set_ent(2, 116, 100, 8, 8, 1'b1);
        do_scan(100, 100, 16, 16, 1, lat);
        check_res("touch", 0, 0, 0);

        // Far edge sums must not wrap
        tbl_default();
        set_ent(0, 1015, 500, 63, 63, 1'b1);
        do_scan(5, 5, 16, 16, 1, lat);
        check_res("nowrap", 0, 0, 0);

        // Start while busy: exactly one scan
        tbl_default();
        set_ent(3, 110, 110, 8, 8, 1'b1);
        @(negedge clk);
        d0 = n_done; r0 = n_rden;
        drive_ref(100, 100, 16, 16);
        bus.i_Start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.i_Start = 1'b0;
        while (cyc < t0 + 4) @(negedge clk);
        bus.i_Start = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        while (cyc < t0 + 40) @(negedge clk);
        check("busy_start_dones", 32'(n_done - d0), 32'd1);
        check("busy_start_reads", 32'(n_rden - r0), 32'(N));
        check("busy_start_done_cycle", 32'(last_done - t0), 32'(N + 2));
        check_res("busy_start", 1, 3, 1);

        // Asynchronous reset mid-scan
        @(negedge clk);
        drive_ref(100, 100, 16, 16);
        bus.i_Start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.i_Start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.o_Busy), 32'd0);
        check("midrst_rd_en", 32'(bus.o_RdEn), 32'd0);
        check_res("midrst", 0, 0, 0);
        d0 = n_done;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        do_scan(100, 100, 16, 16, 1, lat);
        check_res("after_rst", 1, 3, 1);

        // Randomized scans
        for (int s = 0; s < 40; s++) begin
            int rx, ry, rw, rh;
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(0, 511));
            rw = int'($urandom_range(0, 31));
            rh = int'($urandom_range(0, 31));
            self_sel = int'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) begin
                set_ent(i,
                        clampi(rx + int'($urandom_range(0, 60)) - 30, 0, 1023),
                        clampi(ry + int'($urandom_range(0, 60)) - 30, 0, 511),
                        ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                        ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                        $urandom_range(0, 3) != 0);
            end
            do_scan(rx, ry, rw, rh, int'($urandom_range(1, 3)), lat);
            if ($urandom_range(0, 1) == 1) begin
                bus.i_Start = 1'b1;   // lands in the DONE cycle: ignored
                @(negedge clk);
                bus.i_Start = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
